// File: rtl/mem_axi_bridge.sv
// Turns each single-beat MMU memory request into one AXI4-Lite read or write and returns the result.
// One transaction in flight; every AXI output is registered, so no AXI input reaches an AXI output combinationally.
module mem_axi_bridge #(
  parameter int unsigned           ADDR_W      = 32,
  parameter int unsigned           DATA_W      = 32,
  parameter logic [DATA_W-1:0]     RESET_RDATA = '0
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  request_enable,
  input  logic                  req_mode,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wstrb,

  output logic                  response_enable,
  output logic [DATA_W-1:0]     resp_data,
  output logic                  resp_error,
  output logic                  busy,

  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,

  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,

  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,

  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,

  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_RD_ADDR      = 3'd1;
  localparam logic [2:0] ST_RD_DATA      = 3'd2;
  localparam logic [2:0] ST_WR_ADDR_DATA = 3'd3;
  localparam logic [2:0] ST_WR_RESP      = 3'd4;
  localparam logic [2:0] ST_DONE         = 3'd5;

  logic [2:0]          state_q,     state_d;
  logic [ADDR_W-1:0]   addr_q,      addr_d;
  logic [DATA_W-1:0]   wdata_q,     wdata_d;
  logic [DATA_W/8-1:0] wstrb_q,     wstrb_d;
  logic                arvalid_q,   arvalid_d;
  logic                rready_q,    rready_d;
  logic                awvalid_q,   awvalid_d;
  logic                wvalid_q,    wvalid_d;
  logic                bready_q,    bready_d;
  logic                aw_done_q,   aw_done_d;
  logic                w_done_q,    w_done_d;
  logic                resp_en_q,   resp_en_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic                resp_err_q,  resp_err_d;
  logic                busy_q,      busy_d;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

  assign ar_hs = arvalid_q && m_axi_arready;
  assign r_hs  = rready_q  && m_axi_rvalid;
  assign aw_hs = awvalid_q && m_axi_awready;
  assign w_hs  = wvalid_q  && m_axi_wready;
  assign b_hs  = bready_q  && m_axi_bvalid;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    resp_en_d   = 1'b0;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    busy_d      = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (request_enable) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          busy_d  = 1'b1;
          if (req_mode) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = ST_WR_ADDR_DATA;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_ADDR;
          end
        end
      end

      // rready only rises after the AR handshake, so an early rvalid is never taken.
      ST_RD_ADDR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end
      end

      ST_RD_DATA: begin
        if (r_hs) begin
          rready_d    = 1'b0;
          resp_data_d = m_axi_rdata;
          resp_err_d  = |m_axi_rresp;
          resp_en_d   = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_DONE;
        end
      end

      ST_WR_ADDR_DATA: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end

      ST_WR_RESP: begin
        if (b_hs) begin
          bready_d    = 1'b0;
          resp_data_d = RESET_RDATA;
          resp_err_d  = |m_axi_bresp;
          resp_en_d   = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      resp_en_q   <= 1'b0;
      resp_data_q <= RESET_RDATA;
      resp_err_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      resp_en_q   <= resp_en_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign response_enable = resp_en_q;
  assign resp_data       = resp_data_q;
  assign resp_error      = resp_err_q;
  assign busy            = busy_q;

  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Randomized bench for mem_axi_bridge: the bench plays AXI slave with chosen wait states and
// predicts every control output per cycle from the handshake timing rules.
module tb_mem_axi_bridge;

  localparam logic [31:0] RST_RD = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        request_enable, req_mode;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        response_enable, resp_error, busy;
  logic [31:0] resp_data;
  logic [31:0] m_axi_araddr, m_axi_rdata, m_axi_awaddr, m_axi_wdata;
  logic [2:0]  m_axi_arprot, m_axi_awprot;
  logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready;
  logic [1:0]  m_axi_rresp, m_axi_bresp;
  logic [3:0]  m_axi_wstrb;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_axi_bridge #(.ADDR_W(32), .DATA_W(32), .RESET_RDATA(RST_RD)) dut (
    .clk(clk), .rst(rst),
    .request_enable(request_enable), .req_mode(req_mode), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .response_enable(response_enable), .resp_data(resp_data), .resp_error(resp_error), .busy(busy),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // {arvalid, rready, awvalid, wvalid, bready, busy, response_enable}
  function automatic logic [6:0] stat();
    return {m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
            busy, response_enable};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_idle();
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = 32'h0; m_axi_rresp = 2'b00;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
  endtask

  task automatic start_req(input logic md, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws);
    request_enable = 1'b1; req_mode = md; req_addr = a; req_wdata = wd; req_wstrb = ws;
    step();
    request_enable = 1'b0;
  endtask

  // k counts edges after the accepting edge; outputs are sampled 1ns after each edge.
  // A stray request is pulsed at k == spur (negative: none) and must be ignored.
  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] rr,
                         input int arw, input int rw, input int spur);
    int kr;
    logic [6:0] e;
    kr = arw + ((rw < 1) ? 1 : rw) + 1;
    start_req(1'b0, a, 32'h0, 4'h0);
    for (int k = 0; k <= kr + 1; k++) begin
      e = {k <= arw, (k > arw) && (k < kr), 1'b0, 1'b0, 1'b0, k < kr, k == kr};
      chk("rd_ctl", stat(), e);
      if (k <= arw) chk("araddr", m_axi_araddr, a);
      if (k == kr) begin
        chk("rd_data", resp_data, d);
        chk("rd_err", resp_error, |rr);
      end
      if (k == kr + 1) chk("rd_hold", resp_data, d);
      m_axi_arready = (k == arw);
      m_axi_rvalid  = (k >= arw + rw) && (k < kr);
      m_axi_rdata   = m_axi_rvalid ? d : $urandom;
      m_axi_rresp   = m_axi_rvalid ? rr : 2'($urandom);
      request_enable = (k == spur);
      req_mode = 1'($urandom); req_addr = ~a; req_wdata = $urandom; req_wstrb = 4'($urandom);
      if (k <= kr) step();
      else begin
        slave_idle();
        request_enable = 1'b0;
      end
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input logic [1:0] br, input int aww, input int ww, input int bw,
                          input int spur);
    int m, kr;
    logic [6:0] e;
    m  = (aww > ww) ? aww : ww;
    kr = m + ((bw < 1) ? 1 : bw) + 1;
    start_req(1'b1, a, wd, ws);
    for (int k = 0; k <= kr + 1; k++) begin
      e = {1'b0, 1'b0, k <= aww, k <= ww, (k > m) && (k < kr), k < kr, k == kr};
      chk("wr_ctl", stat(), e);
      if (k <= aww) chk("awaddr", m_axi_awaddr, a);
      if (k <= ww) chk("wdata", {m_axi_wstrb, m_axi_wdata}, {ws, wd});
      if (k == kr) begin
        chk("wr_data", resp_data, RST_RD);
        chk("wr_err", resp_error, |br);
      end
      m_axi_awready = (k == aww);
      m_axi_wready  = (k == ww);
      m_axi_bvalid  = (k >= m + bw) && (k < kr);
      m_axi_bresp   = m_axi_bvalid ? br : 2'($urandom);
      request_enable = (k == spur);
      req_mode = 1'($urandom); req_addr = ~a; req_wdata = $urandom; req_wstrb = 4'($urandom);
      if (k <= kr) step();
      else begin
        slave_idle();
        request_enable = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    request_enable = 1'b0; req_mode = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    slave_idle();
    step(); step();
    rst = 1'b0;
    chk("rst_ctl", stat(), 7'b0);
    chk("rst_data", resp_data, RST_RD);
    chk("rst_err", resp_error, 1'b0);
    chk("prot", {m_axi_arprot, m_axi_awprot}, 6'b0);
    step();

    do_read(32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 0, 1, -1);
    do_write(32'h8000_0020, 32'h1234_5678, 4'b0011, 2'b00, 3, 0, 1, -1);
    do_read(32'h8000_0030, 32'h0BAD_F00D, 2'b00, 5, 1, 2);
    do_read(32'h8000_0034, 32'h5555_AAAA, 2'b10, 0, 0, -1);
    do_write(32'h8000_0038, 32'hCAFE_0001, 4'b1111, 2'b11, 0, 0, 1, -1);
    do_write(32'h8000_003C, 32'h7777_0000, 4'b1000, 2'b00, 1, 1, 0, 3);

    // abandon a read while rready is up: everything quiet, no response ever appears
    start_req(1'b0, 32'h8000_0040, 32'h0, 4'h0);
    m_axi_arready = 1'b1;
    step();
    m_axi_arready = 1'b0;
    chk("mid_pre", stat(), 7'b0100010);
    rst = 1'b1;
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'h1111_2222;
    step();
    rst = 1'b0;
    slave_idle();
    chk("mid_rst", stat(), 7'b0);
    chk("mid_data", resp_data, RST_RD);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_quiet", stat(), 7'b0);
    end
    do_read(32'h8000_0044, 32'h0F0F_F0F0, 2'b00, 1, 2, -1);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, d;
      int sp;
      a  = $urandom; d = $urandom;
      sp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : -1;
      if ($urandom_range(0, 1) == 0)
        do_read(a, d, 2'($urandom_range(0, 3) == 0 ? $urandom : 0),
                $urandom_range(0, 4), $urandom_range(0, 3), sp);
      else
        do_write(a, d, 4'($urandom), 2'($urandom_range(0, 3) == 0 ? $urandom : 0),
                 $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3), sp);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        step();
        chk("gap_quiet", stat(), 7'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_axi_bridge.md
Name: mem_axi_bridge

Overview:
- Downstream neighbour of the MMU wrapper.
- Consumes its single physical-address memory request port (request_enable/req_mode/req_addr/req_wdata/req_wstrb) and returns response_enable/resp_data.
- Converts each request into one AXI4-Lite master transaction toward the memory/peripheral interconnect.
- Serves exactly one outstanding transaction; reports bus errors to the core.

Parameters:
- ADDR_W, 32, AXI address width; req_addr is passed through unchanged.
- DATA_W, 32, data width; fixed at 32 for this core.
- RESET_RDATA, 32'h0, value resp_data holds after reset and drives on write responses.

Ports:
- clk  input  1  core clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- request_enable  input  1  one-cycle request pulse from the MMU.
- req_mode  input  1  0 = read, 1 = write.
- req_addr  input  32  physical byte address.
- req_wdata  input  32  write data.
- req_wstrb  input  4  byte enables for a write.
- response_enable  output  1  one-cycle completion pulse.
- resp_data  output  32  read data; RESET_RDATA for writes.
- resp_error  output  1  valid with response_enable; 1 if RRESP/BRESP is nonzero.
- busy  output  1  high from the cycle after acceptance until the response pulse.
- m_axi_araddr  output  32; m_axi_arvalid  output  1; m_axi_arready  input  1.
- m_axi_rdata  input  32; m_axi_rresp  input  2; m_axi_rvalid  input  1; m_axi_rready  output  1.
- m_axi_awaddr  output  32; m_axi_awvalid  output  1; m_axi_awready  input  1.
- m_axi_wdata  output  32; m_axi_wstrb  output  4; m_axi_wvalid  output  1; m_axi_wready  input  1.
- m_axi_bresp  input  2; m_axi_bvalid  input  1; m_axi_bready  output  1.
- m_axi_arprot, m_axi_awprot  output  3  constant 3'b000.

Behaviour:
- Reset (rst=1 at an edge) forces:
  - state IDLE;
  - all valid/ready outputs, response_enable, resp_error and busy to 0;
  - resp_data to RESET_RDATA;
  - address/data registers to 0.
- Reset mid-transaction abandons it immediately. No response is issued.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, DONE.
- IDLE: request_enable=1 at edge T latches addr/wdata/wstrb/mode.
  - Read: m_axi_araddr valid and m_axi_arvalid=1 from T+1.
  - Write: awvalid and wvalid both 1 from T+1.
  - busy=1 from T+1.
- request_enable while busy or in DONE is ignored. The upstream side guarantees it only issues a request after the response for the previous one.
- RD_ADDR:
  - arvalid held with stable araddr until arvalid&&arready.
  - On the handshake: arvalid drops next cycle, rready rises next cycle, state goes to RD_DATA.
- RD_DATA:
  - rready=1. On rvalid&&rready, capture rdata into resp_data and resp_error=|rresp.
  - rready drops next cycle; go to DONE.
  - rvalid arriving in the same cycle as the AR handshake is not accepted; rready is 0 there.
- WR_ADDR_DATA:
  - AW and W channels complete independently. awvalid drops the cycle after its handshake, wvalid likewise.
  - Order is unconstrained: AW first, W first, or both in the same cycle.
  - When both are done (both flags set, or both handshake in the same cycle), bready=1 next cycle and state goes to WR_RESP.
- WR_RESP:
  - On bvalid&&bready: resp_error=|bresp, resp_data=RESET_RDATA, bready drops; go to DONE.
- DONE:
  - response_enable=1 for exactly one cycle; busy=0 in that same cycle; return to IDLE.
  - A new request is accepted the following cycle at the earliest.
- Best-case latency with zero-wait slave (request edge T):
  - Read: AR handshake T+1, R handshake T+2, response_enable at T+3.
  - Write: AW/W handshake T+1, B handshake T+2, response_enable at T+3.
- resp_data and resp_error hold their last values until the next completion.
- AXI rules: once asserted, a valid never deasserts before its ready, and its payload stays stable. No combinational path from any AXI input to any AXI output.

Test Plan:
- Zero-wait read: req addr 0x8000_0010, slave returns 0xDEAD_BEEF, rresp=0 -> arvalid at T+1; response_enable at T+3 only; resp_data=0xDEAD_BEEF; resp_error=0.
- Write, W before AW: wdata 0x1234_5678, wstrb 4'b0011 to 0x8000_0020; wready at T+1, awready at T+4 -> wvalid low from T+2, awvalid low from T+5, bready at T+5; response after bvalid; resp_data=RESET_RDATA.
- Backpressure: arready held low 5 cycles -> araddr and arvalid stable all 5 cycles; busy=1; a request_enable pulse during the wait is ignored (no second AR).
- Errors: rresp=2'b10 on a read -> resp_error=1 with response_enable. A following write with bresp=2'b11 -> resp_error=1.
- Reset mid-read: rst asserted while in RD_DATA -> next cycle all valids/readies 0, busy=0, no response_enable; a new read issued afterwards completes normally.
- Back-to-back: new request in the cycle after response_enable -> accepted; arvalid two cycles after the pulse.
